// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared types and constants for the OBI responder memory
package cv32e40x_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_slave_resp_t;

  localparam logic [7:0] OBI_SLAVE_LFSR_SEED = 8'hA5;

  // Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
  function automatic logic [7:0] obi_slave_lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/cv32e40x_obi_resp_pipe.sv
// rtl/cv32e40x_obi_resp_pipe.sv - fixed-depth valid/response delay line, no backpressure
module cv32e40x_obi_resp_pipe
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  input  obi_slave_resp_t in_resp_i,
  output logic            out_valid_o,
  output obi_slave_resp_t out_resp_o
);

  logic            [DEPTH-1:0] valid_q, valid_d;
  obi_slave_resp_t [DEPTH-1:0] resp_q, resp_d;

  // Payload is zeroed whenever its stage is invalid so the R channel idles at 0.
  always_comb begin
    valid_d    = valid_q;
    resp_d     = resp_q;
    valid_d[0] = in_valid_i;
    resp_d[0]  = in_valid_i ? in_resp_i : '0;
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = valid_q[i-1];
      resp_d[i]  = resp_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      resp_q  <= '0;
    end else begin
      valid_q <= valid_d;
      resp_q  <= resp_d;
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_resp_o  = resp_q[DEPTH-1];

endmodule

// File: rtl/cv32e40x_obi_slave_mem.sv
// rtl/cv32e40x_obi_slave_mem.sv - word-addressed OBI responder backed by a local memory
// CV32E40X_OBI_SLAVE_STALL_EN adds LFSR-driven pseudo-random grant stalls.
module cv32e40x_obi_slave_mem
  import cv32e40x_pkg::*;
#(
  parameter int unsigned WORDS           = 256,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);

  logic [31:0]     mem_q [WORDS];
  logic [AW-1:0]   word_idx;
  logic            in_range;
  logic            accept;
  logic            stall;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  obi_slave_resp_t req_resp;
  obi_slave_resp_t out_resp;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^obi_addr_i[1:0];
  assign word_idx = obi_addr_i[2 +: AW];
  assign in_range = ~|obi_addr_i[31:2+AW];

`ifdef CV32E40X_OBI_SLAVE_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = obi_slave_lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= OBI_SLAVE_LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Limit is checked against the registered count: a retiring beat does not free a slot this cycle.
  assign obi_gnt_o = obi_req_i && !rst && (outstanding_q < MAX_OUT) && !stall;
  assign accept    = obi_req_i && obi_gnt_o;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, obi_rvalid_o})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding_q <= '0;
    else     outstanding_q <= outstanding_d;
  end

  always_comb begin
    req_resp.rdata = (in_range && !obi_we_i) ? mem_q[word_idx] : 32'h0;
    req_resp.err   = !in_range;
  end

  always_ff @(posedge clk) begin
    if (accept && in_range && obi_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (obi_be_i[b]) mem_q[word_idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
      end
    end
  end

  cv32e40x_obi_resp_pipe #(
    .DEPTH (RESP_LATENCY)
  ) u_resp_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (accept),
    .in_resp_i   (req_resp),
    .out_valid_o (obi_rvalid_o),
    .out_resp_o  (out_resp)
  );

  assign obi_rdata_o = out_resp.rdata;
  assign obi_err_o   = out_resp.err;

endmodule
